seg_scan_sched: RTL
===================

# seg_scan_sched

Time-multiplexing scheduler for the board's 8-digit, common-anode seven-segment display.
- The display is shared between eight 4-bit digit sources, typically the BCD/hex outputs of the tick-driven counter channels.
- The block rotates one digit at a time through fixed-length scan slots and skips masked digits.
- It inserts a blanking interval before each digit to suppress ghosting.
- Input data is snapshotted once per frame so a counter update never tears a displayed frame.

## Interface
Parameters:
- SCAN_DIV, 200000: slot length in clk cycles (2 ms at 100 MHz); must be ≥ BLANK_CYC+1.
- BLANK_CYC, 1000: blank cycles at the start of each slot; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- data  in  32  digit i value = data[4i+3:4i], hex 0–F.
- digit_mask  in  8  bit i = 1: digit i participates in the scan.
- dp_mask  in  8  bit i = 1: decimal point lit on digit i.
- led_en  out  8  digit anode enables, active low.
- led_seg  out  8  {dp,g,f,e,d,c,b,a}, active low.
- frame_start  out  1  one-cycle pulse when a new frame snapshot is taken.

## Operation
- Snapshot registers: `s_data`, `s_mask`, `s_dp`. Live inputs are used only at snapshot time.
- Slot timer: width clog2(SCAN_DIV), counts 0..SCAN_DIV-1.
- Digit index: `idx[2:0]`.

States:
- IDLE: all dark.
  - Each cycle, if live digit_mask ≠ 0: take a snapshot, set idx = lowest set bit of digit_mask, set timer = 0, pulse frame_start, go to BLANK.
- BLANK: led_en = 8'hFF, led_seg = 8'hFF.
  - When timer = BLANK_CYC-1: go to SHOW.
- SHOW: led_en = ~(1<<idx), led_seg = decode(s_data digit idx), with dp = ~s_dp[idx].
  - When timer = SCAN_DIV-1 (end of slot): search s_mask circularly from idx+1.
  - If the first set bit found has index > idx: go to that idx, timer = 0, BLANK. No snapshot.
  - Otherwise (wrap, including a single-digit mask): this is a frame boundary.
    - If live digit_mask ≠ 0: snapshot, idx = lowest set bit of the new mask, pulse frame_start, timer = 0, BLANK.
    - If live digit_mask = 0: go to IDLE with no pulse.

Digit decode (active low, dp bit = 1):
- 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8
- 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E
- A set s_dp bit clears bit 7.

Other rules:
- Masks are never re-sampled mid-frame. Clearing a mask bit takes effect at the next frame boundary.
- Timer increments every cycle in BLANK/SHOW and is held at 0 in IDLE.

## Timing
- All outputs are registered and change on the same clk edge as the state. Outputs always match the current state.
- Reset values: state IDLE, idx 0, timer 0, snapshots 0, led_en 8'hFF, led_seg 8'hFF, frame_start 0.
- IDLE → BLANK takes 1 cycle after digit_mask becomes non-zero. frame_start is high in the first BLANK cycle.
- Slot: exactly BLANK_CYC cycles dark, then SCAN_DIV-BLANK_CYC cycles lit.
- Frame length = SCAN_DIV × popcount(s_mask) cycles. frame_start period equals the frame length while the mask is constant.
- Never two lit anodes. led_en is never low in BLANK or IDLE.
- Reset mid-slot: outputs go dark immediately (asynchronous). Operation restarts from IDLE after rst deasserts.
- Data changing on the frame_start cycle is not captured; the snapshot uses the value sampled on the transition edge.

## Test plan
All scenarios use SCAN_DIV=8, BLANK_CYC=2.
- Reset, then digit_mask=0: led_en=FF, led_seg=FF, frame_start=0 indefinitely.
- digit_mask=01, data[3:0]=5, dp_mask=00:
  - Repeating 8-cycle slots: 2 cycles FF/FF, then 6 cycles led_en=FE, led_seg=92.
  - frame_start pulses every 8 cycles.
- digit_mask=05, data=32'h0000_0A03, dp_mask=04:
  - Digit order 0, 2, 0, …
  - Digit 0 shows B0 with en=FE; digit 2 shows 08 (A with dp) with en=FB.
  - frame_start every 16 cycles.
- Change data mid-frame (mask=03): new values appear only from the slot following the next frame_start; the current frame shows the old values.
- Clear digit_mask to 00 during digit 0's SHOW with mask=03:
  - Digit 1 is still displayed.
  - At its slot end the block enters IDLE and outputs go dark.
  - Setting mask=80 restarts at digit 7 one cycle later, with frame_start.
- Assert rst during a SHOW cycle: led_en/led_seg read FF in the same cycle. After release, the IDLE → BLANK restart follows the stated latency.

Source files
------------

// File: rtl/seg_scan_sched.sv
// rtl/seg_scan_sched.sv - eight-digit seven-segment scan scheduler with blanking and frame snapshot
module seg_scan_sched #(
    parameter int SCAN_DIV  = 200000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [7:0]  digit_mask,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  led_en,
    output logic [7:0]  led_seg,
    output logic        frame_start
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);
    localparam logic [TW-1:0] SLOT_LAST  = TW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t        state, state_n;
    logic [2:0]    idx, idx_n;
    logic [TW-1:0] timer, timer_n;
    logic [31:0]   s_data, s_data_n;
    logic [7:0]    s_mask, s_mask_n;
    logic [7:0]    s_dp, s_dp_n;
    logic [7:0]    en_n, seg_n;
    logic          fs_n;
    logic          take;
    logic          above;
    logic [2:0]    nxt;

    // Segment pattern {g,f,e,d,c,b,a}, active low
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    // Index of the lowest set bit; only called with a non-zero mask
    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_bit = 3'(i);
        end
    endfunction

    // Next-state, snapshot capture and registered-output values
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        timer_n  = timer;
        s_data_n = s_data;
        s_mask_n = s_mask;
        s_dp_n   = s_dp;
        fs_n     = 1'b0;
        take     = 1'b0;
        above    = 1'b0;
        nxt      = 3'd0;
        en_n     = 8'hFF;
        seg_n    = 8'hFF;

        // Next participating digit strictly above idx; none means the frame wraps
        for (int i = 7; i >= 0; i--) begin
            if (s_mask[i] && (3'(i) > idx)) begin
                above = 1'b1;
                nxt   = 3'(i);
            end
        end

        case (state)
            IDLE: begin
                timer_n = '0;
                if (digit_mask != 8'h00) take = 1'b1;
            end
            BLANK: begin
                timer_n = timer + TW'(1);
                if (timer == BLANK_LAST) state_n = SHOW;
            end
            SHOW: begin
                if (timer == SLOT_LAST) begin
                    timer_n = '0;
                    if (above) begin
                        idx_n   = nxt;
                        state_n = BLANK;
                    end else if (digit_mask != 8'h00) begin
                        take = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase

        if (take) begin
            s_data_n = data;
            s_mask_n = digit_mask;
            s_dp_n   = dp_mask;
            idx_n    = lowest_bit(digit_mask);
            timer_n  = '0;
            state_n  = BLANK;
            fs_n     = 1'b1;
        end

        if (state_n == SHOW) begin
            en_n  = ~(8'd1 << idx_n);
            seg_n = {~s_dp_n[idx_n], decode(s_data_n[{idx_n, 2'b00} +: 4])};
        end
    end

    // State, snapshot and output registers; reset darkens the display at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 3'd0;
            timer       <= '0;
            s_data      <= 32'h0;
            s_mask      <= 8'h00;
            s_dp        <= 8'h00;
            led_en      <= 8'hFF;
            led_seg     <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            timer       <= timer_n;
            s_data      <= s_data_n;
            s_mask      <= s_mask_n;
            s_dp        <= s_dp_n;
            led_en      <= en_n;
            led_seg     <= seg_n;
            frame_start <= fs_n;
        end
    end

endmodule
